mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory stage plus MEM/WB pipeline register and write-back mux of the ARM pipeline.
- Consumes the EXE/MEM register outputs, services loads and stores against an internal word-addressed data memory, and produces the write-back triple (wb_dest, wb_value, wb_wb_en) that the decode stage uses for register-file writes.
- Drives mem_stall to the hazard/freeze logic when multi-cycle memory is compiled in.

Parameters:
- DEPTH, 64, number of 32-bit data-memory words; must be a power of two.
- BASE_ADDR, 1024, byte address of word 0.
- WAIT_CYCLES, 4, total cycles per memory access when MEM_WAIT_EN is defined; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- wb_en  in  1  instruction writes a register.
- mem_r_en  in  1  load.
- mem_w_en  in  1  store.
- alu_result  in  32  byte address for load/store, or ALU result otherwise.
- value_rm  in  32  store data.
- dest  in  4  destination register.
- wb_dest  out  4  register-file write index.
- wb_value  out  32  register-file write data.
- wb_wb_en  out  1  register-file write enable.
- mem_stall  out  1  memory busy; upstream must freeze.
- addr_err  out  1  one-cycle registered pulse: access outside the memory window.

Behaviour:
- Reset: all of the following clear synchronously when rst is low at a clock edge:
  - MEM/WB register: wb_en_q, mem_r_en_q, dest_q, alu_q, rdata_q.
  - addr_err.
  - FSM state = IDLE, counter = 0.
  - Memory contents are not cleared.
- Index and range:
  - idx = (alu_result - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
  - in_range = alu_result >= BASE_ADDR and alu_result < BASE_ADDR + 4*DEPTH.
  - Low two address bits are ignored.
- access = mem_r_en | mem_w_en.
- Commit cycle:
  - Without MEM_WAIT_EN: every cycle.
  - With MEM_WAIT_EN: every cycle with mem_stall low.
- At a commit edge:
  - Store: mem[idx] <= value_rm if mem_w_en and in_range; out-of-range stores are dropped.
  - Load: rdata_q <= mem[idx] if mem_r_en and in_range, else 0.
  - Capture wb_en_q <= wb_en, mem_r_en_q <= mem_r_en, dest_q <= dest, alu_q <= alu_result.
  - addr_err <= access and not in_range.
- Stall edges (mem_stall high): load a bubble.
  - wb_en_q = 0, mem_r_en_q = 0, addr_err = 0.
  - No memory write.
- Write-back outputs (combinational from the MEM/WB register):
  - wb_dest = dest_q.
  - wb_wb_en = wb_en_q.
  - wb_value = mem_r_en_q ? rdata_q : alu_q.
- Latency: one cycle from a committed input to valid wb_* outputs.
- Simultaneous mem_r_en and mem_w_en is illegal; if it occurs, the store takes effect and the load returns the old word.
- A store then a load to the same address in consecutive instructions: the load sees the new data.

Optional Feature:
- MEM_WAIT_EN defined: FSM with states IDLE and BUSY, plus a counter of width clog2(WAIT_CYCLES).
  - mem_stall = access && !(state==BUSY && cnt==WAIT_CYCLES-1) && WAIT_CYCLES>1.
  - IDLE, access, WAIT_CYCLES>1 -> BUSY, cnt = 1.
  - BUSY, cnt < WAIT_CYCLES-1 -> cnt+1.
  - BUSY, cnt == WAIT_CYCLES-1 -> commit, then IDLE, cnt = 0.
  - Upstream holds inputs stable while mem_stall is high.
  - Reset mid-access: IDLE, no write, stall drops.
  - Net effect: each access occupies WAIT_CYCLES cycles, with WAIT_CYCLES-1 bubbles on wb_wb_en.
- MEM_WAIT_EN undefined: mem_stall tied 0, no FSM; single-cycle behaviour as above.

Decomposition:
- Shared package arm_pkg:
  - REG_IDX_W = 4, WORD_W = 32.
  - Memory-map constants DMEM_BASE_ADDR and DMEM_DEPTH.
  - mem_state_t enum {IDLE, BUSY}.
- One natural sub-module, data_memory: synchronous write and read, word array, range check.
- The stage wraps it with the pipeline register and the FSM.

Test Plan:
- Reset low for 2 cycles with wb_en=1 -> wb_wb_en=0, wb_value=0, mem_stall=0 and addr_err=0 during and after reset.
- ALU op: wb_en=1, alu_result=0x1234, dest=5 -> next cycle wb_wb_en=1, wb_dest=5, wb_value=0x1234.
- Store 0xDEADBEEF at address 1028, then load from 1028 with dest=3 -> cycle after the load: wb_value=0xDEADBEEF, wb_dest=3.
- Load from 1020 and from 1280 (out of range) -> wb_value=0, addr_err pulses one cycle each; memory unchanged, checked by loads from 1024 and 1276.
- MEM_WAIT_EN, WAIT_CYCLES=4, load held stable -> mem_stall high for 3 cycles, wb_wb_en low for 3 cycles, then one wb_wb_en pulse with the loaded data.
- MEM_WAIT_EN, store in flight, rst low at cnt=2 -> state IDLE, mem_stall=0; a subsequent load returns the pre-store value.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared ARM pipeline definitions: register/word widths, data-memory map,
// and the multi-cycle memory FSM state type.
package arm_pkg;

  localparam int unsigned REG_IDX_W      = 4;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned DMEM_BASE_ADDR = 1024;
  localparam int unsigned DMEM_DEPTH     = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_wb_stage_data_memory.sv
// Word-addressed data memory: synchronous write, registered read, and the
// address-window range check. Low two byte-address bits are ignored.
module data_memory
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH     = DMEM_DEPTH,
  parameter int unsigned BASE_ADDR = DMEM_BASE_ADDR
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_commit,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [WORD_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_in_range
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned EXT_W = WORD_W + 1;
  localparam logic [EXT_W-1:0] LIMIT = EXT_W'(BASE_ADDR) + EXT_W'(4 * DEPTH);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;
  logic [IDX_W-1:0]  w_idx;

  assign w_idx      = IDX_W'((i_addr - WORD_W'(BASE_ADDR)) >> 2);
  assign o_in_range = (i_addr >= WORD_W'(BASE_ADDR)) && ({1'b0, i_addr} < LIMIT);
  assign o_rdata    = r_rdata;

  // Store on commit; out-of-range stores are dropped, nothing written in reset.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_commit && i_we && o_in_range) begin
      r_mem[w_idx] <= i_wdata;
    end
  end

  // Registered load data; reads the pre-store word on a simultaneous store.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_commit) begin
      r_rdata <= (i_re && o_in_range) ? r_mem[w_idx] : '0;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory stage, MEM/WB pipeline register and write-back mux.
// Define MEM_WAIT_EN to make each memory access take WAIT_CYCLES cycles,
// stalling upstream via mem_stall; otherwise memory is single-cycle.
module mem_wb_stage
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH       = DMEM_DEPTH,
  parameter int unsigned BASE_ADDR   = DMEM_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_en,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic [WORD_W-1:0]    alu_result,
  input  logic [WORD_W-1:0]    value_rm,
  input  logic [REG_IDX_W-1:0] dest,
  output logic [REG_IDX_W-1:0] wb_dest,
  output logic [WORD_W-1:0]    wb_value,
  output logic                 wb_wb_en,
  output logic                 mem_stall,
  output logic                 addr_err
);

  logic                 w_access;
  logic                 w_stall;
  logic                 w_commit;
  logic                 w_in_range;
  logic [WORD_W-1:0]    w_rdata;

  logic                 r_wb_en;
  logic                 r_mem_r_en;
  logic                 r_addr_err;
  logic [REG_IDX_W-1:0] r_dest;
  logic [WORD_W-1:0]    r_alu;

  assign w_access = mem_r_en | mem_w_en;
  assign w_commit = !w_stall;

`ifdef MEM_WAIT_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;

  // Stall every access cycle except the final one, where the access commits.
  assign w_stall = w_access && !(r_state == BUSY && r_cnt == CNT_LAST) && (WAIT_CYCLES > 1);

  // Access timer: IDLE -> BUSY on an access, back to IDLE on the commit cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_access && (WAIT_CYCLES > 1)) begin
            r_state <= BUSY;
            r_cnt   <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end
`else
  logic w_unused_wait_cfg;
  assign w_unused_wait_cfg = (WAIT_CYCLES != 0);
  assign w_stall = 1'b0;
`endif

  data_memory #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE_ADDR)
  ) u_dmem (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_commit  (w_commit),
    .i_re      (mem_r_en),
    .i_we      (mem_w_en),
    .i_addr    (alu_result),
    .i_wdata   (value_rm),
    .o_rdata   (w_rdata),
    .o_in_range(w_in_range)
  );

  // MEM/WB register: capture on commit, insert a bubble while stalled.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_dest     <= '0;
      r_alu      <= '0;
      r_addr_err <= 1'b0;
    end else if (w_commit) begin
      r_wb_en    <= wb_en;
      r_mem_r_en <= mem_r_en;
      r_dest     <= dest;
      r_alu      <= alu_result;
      r_addr_err <= w_access && !w_in_range;
    end else begin
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_addr_err <= 1'b0;
    end
  end

  assign wb_dest   = r_dest;
  assign wb_wb_en  = r_wb_en;
  assign wb_value  = r_mem_r_en ? w_rdata : r_alu;
  assign mem_stall = w_stall;
  assign addr_err  = r_addr_err;

endmodule
